// File: rtl/scmp_bus_pkg.sv
// rtl/scmp_bus_pkg.sv - shared types and status-nibble encoding for the SC/MP bus responder
package scmp_bus_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    RDY    = 3'd2,
    WAITWR = 3'd3,
    WRDONE = 3'd4
  } state_t;

  // Bit positions of the cycle status carried on D during the address strobe.
  localparam int ST_H = 7;
  localparam int ST_D = 6;
  localparam int ST_I = 5;
  localparam int ST_R = 4;

  typedef struct packed {
    logic       h;
    logic       d;
    logic       i;
    logic       r;
    logic [3:0] a_hi;
  } ads_status_t;

  // Compares only the address bits above the window; a 16-bit window matches everything.
  function automatic logic win_hit(input logic [15:0] a, input logic [15:0] base,
                                   input int win_bits);
    logic [15:0] mask;
    mask = (win_bits >= 16) ? 16'h0000 : (16'hFFFF << win_bits);
    return ((a ^ base) & mask) == 16'h0000;
  endfunction

endpackage

// File: rtl/scmp_bus_responder_reg8.sv
// rtl/scmp_bus_responder_reg8.sv - 8-bit enabled register with async active-low clear
module reg8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] d,
  output logic [7:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 8'h00;
    else if (en) q <= d;
  end

endmodule

// File: rtl/scmp_bus_responder.sv
// rtl/scmp_bus_responder.sv - SC/MP external bus target: window decode, memory bridge, read drive
module scmp_bus_responder
  import scmp_bus_pkg::*;
#(
  parameter logic [15:0] BASE     = 16'h0000,
  parameter int          WIN_BITS = 12,
  parameter int          MEM_LAT  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ads_n,
  input  logic                rd_n,
  input  logic                wr_n,
  input  logic [11:0]         addr_i,
  input  logic [7:0]          d_i,
  output logic [7:0]          d_o,
  output logic                d_oe,
  output logic                sel,
  output logic [3:0]          cyc_flags,
  output logic                halt_pulse,
  output logic [WIN_BITS-1:0] mem_addr,
  output logic                mem_re,
  output logic                mem_we,
  output logic [7:0]          mem_wdata,
  input  logic [7:0]          mem_rdata,
  output logic                proto_err
);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        rd_low_q, rd_low_d;
  logic        cyc_valid_q;
  logic        mem_re_d, mem_we_d, d_oe_d, capture, err_set;
  logic        ads, rd, wr, hit;
  logic [15:0] addr_in, addr16;
  logic [7:0]  ahi_q, alo_q, data_q;

  assign ads     = !ads_n;
  assign rd      = !rd_n;
  assign wr      = !wr_n;
  assign addr_in = {d_i[3:0], addr_i};
  assign hit     = win_hit(addr_in, BASE, WIN_BITS);

  reg8 u_addr_hi (.clk(clk), .rst_n(rst_n), .en(ads),     .d(addr_in[15:8]), .q(ahi_q));
  reg8 u_addr_lo (.clk(clk), .rst_n(rst_n), .en(ads),     .d(addr_in[7:0]),  .q(alo_q));
  reg8 u_data    (.clk(clk), .rst_n(rst_n), .en(capture), .d(mem_rdata),     .q(data_q));

  assign addr16   = {ahi_q, alo_q};
  assign mem_addr = addr16[WIN_BITS-1:0];
  // The cleared latch would decode as a hit, so sel also waits for a first address phase.
  assign sel      = cyc_valid_q & win_hit(addr16, BASE, WIN_BITS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_low_d = rd_low_q;
    mem_re_d = 1'b0;
    mem_we_d = 1'b0;
    d_oe_d   = 1'b0;
    capture  = 1'b0;
    err_set  = 1'b0;
    if (ads) begin
      // Address phase overrides whatever cycle was in flight.
      err_set  = rd | wr;
      rd_low_d = 1'b0;
      if (!hit) begin
        state_d = IDLE;
      end else if (d_i[ST_R]) begin
        state_d  = FETCH;
        mem_re_d = 1'b1;
      end else begin
        state_d = WAITWR;
      end
    end else begin
      if (rd && wr) err_set = 1'b1;
      case (state_q)
        FETCH: begin
          if (rd || wr) err_set = 1'b1;
          if (mem_re) begin
            cnt_d = 3'(MEM_LAT - 1);
          end else if (cnt_q == 3'd0) begin
            capture = 1'b1;
            state_d = RDY;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        RDY: begin
          if (wr) err_set = 1'b1;
          d_oe_d = rd;
          if (rd)            rd_low_d = 1'b1;
          else if (rd_low_q) state_d  = IDLE;
        end
        WAITWR: begin
          if (rd) err_set = 1'b1;
          if (wr && !rd) begin
            mem_we_d = 1'b1;
            state_d  = WRDONE;
          end
        end
        WRDONE: begin
          if (!wr) state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= 3'd0;
      rd_low_q    <= 1'b0;
      cyc_valid_q <= 1'b0;
      mem_re      <= 1'b0;
      mem_we      <= 1'b0;
      mem_wdata   <= 8'h00;
      d_oe        <= 1'b0;
      d_o         <= 8'h00;
      cyc_flags   <= 4'h0;
      halt_pulse  <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      rd_low_q   <= rd_low_d;
      mem_re     <= mem_re_d;
      mem_we     <= mem_we_d;
      d_oe       <= d_oe_d;
      d_o        <= data_q;
      halt_pulse <= ads & d_i[ST_H];
      if (mem_we_d) mem_wdata <= d_i;
      if (ads) begin
        cyc_flags   <= d_i[ST_H:ST_R];
        cyc_valid_q <= 1'b1;
      end
      if (err_set) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_scmp_bus_responder.sv
// tb/tb_scmp_bus_responder.sv - directed self-checking bench for scmp_bus_responder
module tb_scmp_bus_responder;

  logic        clk, rst_n, ads_n, rd_n, wr_n;
  logic [11:0] addr_i;
  logic [7:0]  d_i, mem_rdata;

  logic [7:0]  l1_d_o, l3_d_o, l1_mem_wdata, l3_mem_wdata;
  logic        l1_d_oe, l1_sel, l1_halt, l1_mem_re, l1_mem_we, l1_err;
  logic        l3_d_oe, l3_sel, l3_halt, l3_mem_re, l3_mem_we, l3_err;
  logic [3:0]  l1_flags, l3_flags;
  logic [11:0] l1_mem_addr, l3_mem_addr;

  int n_checks = 0;
  int n_fail   = 0;
  int re_cnt   = 0;
  int we_cnt   = 0;
  int r0, w0;

  scmp_bus_responder #(.BASE(16'h0000), .WIN_BITS(12), .MEM_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .ads_n(ads_n), .rd_n(rd_n), .wr_n(wr_n),
    .addr_i(addr_i), .d_i(d_i), .d_o(l1_d_o), .d_oe(l1_d_oe), .sel(l1_sel),
    .cyc_flags(l1_flags), .halt_pulse(l1_halt), .mem_addr(l1_mem_addr),
    .mem_re(l1_mem_re), .mem_we(l1_mem_we), .mem_wdata(l1_mem_wdata),
    .mem_rdata(mem_rdata), .proto_err(l1_err)
  );

  scmp_bus_responder #(.BASE(16'h0000), .WIN_BITS(12), .MEM_LAT(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .ads_n(ads_n), .rd_n(rd_n), .wr_n(wr_n),
    .addr_i(addr_i), .d_i(d_i), .d_o(l3_d_o), .d_oe(l3_d_oe), .sel(l3_sel),
    .cyc_flags(l3_flags), .halt_pulse(l3_halt), .mem_addr(l3_mem_addr),
    .mem_re(l3_mem_re), .mem_we(l3_mem_we), .mem_wdata(l3_mem_wdata),
    .mem_rdata(mem_rdata), .proto_err(l3_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (l1_mem_re) re_cnt++;
    if (l1_mem_we) we_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ads_cycle(input logic [11:0] a, input logic [7:0] s);
    ads_n  = 1'b0;
    addr_i = a;
    d_i    = s;
    tick();
    ads_n = 1'b1;
    d_i   = 8'h00;
  endtask

  initial begin
    rst_n = 1'b0; ads_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    addr_i = 12'h000; d_i = 8'h00; mem_rdata = 8'h00;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    check_eq("rst_d_oe",   l1_d_oe,     0);
    check_eq("rst_d_o",    l1_d_o,      0);
    check_eq("rst_sel",    l1_sel,      0);
    check_eq("rst_flags",  l1_flags,    0);
    check_eq("rst_mem_re", l1_mem_re,   0);
    check_eq("rst_mem_we", l1_mem_we,   0);
    check_eq("rst_err",    l1_err,      0);
    check_eq("rst_addr",   l1_mem_addr, 0);

    // read hit, one-clock memory
    r0 = re_cnt;
    ads_cycle(12'h123, 8'h10);
    mem_rdata = 8'hA5;
    check_eq("rd_mem_re",   l1_mem_re,   1);
    check_eq("rd_mem_addr", l1_mem_addr, 12'h123);
    check_eq("rd_sel",      l1_sel,      1);
    tick();
    check_eq("rd_re_once", l1_mem_re, 0);
    tick();
    rd_n = 1'b0;
    tick();
    check_eq("rd_d_oe", l1_d_oe, 1);
    check_eq("rd_d_o",  l1_d_o,  8'hA5);
    tick();
    rd_n = 1'b1;
    tick();
    check_eq("rd_d_oe_off", l1_d_oe, 0);
    check_eq("rd_re_count", re_cnt - r0, 1);
    check_eq("rd_no_err",   l1_err, 0);

    // write hit, strobe held three clocks
    w0 = we_cnt;
    ads_cycle(12'h0FF, 8'h00);
    wr_n = 1'b0;
    d_i  = 8'h3C;
    repeat (3) tick();
    wr_n = 1'b1;
    d_i  = 8'h00;
    repeat (2) tick();
    check_eq("wr_we_count", we_cnt - w0, 1);
    check_eq("wr_wdata",    l1_mem_wdata, 8'h3C);
    check_eq("wr_addr",     l1_mem_addr,  12'h0FF);
    check_eq("wr_no_err",   l1_err, 0);

    // miss: A15:12 = 1 lies outside the 4 KiB window at 0
    r0 = re_cnt;
    w0 = we_cnt;
    ads_cycle(12'h050, 8'h11);
    check_eq("miss_sel",   l1_sel,   0);
    check_eq("miss_flags", l1_flags, 4'h1);
    rd_n = 1'b0;
    tick();
    check_eq("miss_d_oe_a", l1_d_oe, 0);
    tick();
    check_eq("miss_d_oe_b", l1_d_oe, 0);
    rd_n = 1'b1;
    tick();
    check_eq("miss_no_mem", (re_cnt - r0) + (we_cnt - w0), 0);
    check_eq("miss_no_err", l1_err, 0);

    // halt cycle (R=0, so it also leaves a write pending)
    ads_cycle(12'h000, 8'h80);
    check_eq("halt_pulse", l1_halt,  1);
    check_eq("halt_flags", l1_flags, 4'h8);
    tick();
    check_eq("halt_one_clk", l1_halt, 0);

    // rd_n and wr_n together while waiting for a write
    w0 = we_cnt;
    rd_n = 1'b0;
    wr_n = 1'b0;
    d_i  = 8'h99;
    tick();
    rd_n = 1'b1;
    wr_n = 1'b1;
    d_i  = 8'h00;
    tick();
    check_eq("conf_err",   l1_err, 1);
    check_eq("conf_no_we", we_cnt - w0, 0);

    // abort: second address phase during FETCH drops the first read
    r0 = re_cnt;
    mem_rdata = 8'h11;
    ads_n  = 1'b0;
    addr_i = 12'h010;
    d_i    = 8'h10;
    tick();
    addr_i = 12'h020;
    tick();
    ads_n = 1'b1;
    d_i   = 8'h00;
    tick();
    mem_rdata = 8'h22;
    check_eq("abort_d_oe_idle", l1_d_oe, 0);
    tick();
    rd_n = 1'b0;
    tick();
    check_eq("abort_d_oe",  l1_d_oe,     1);
    check_eq("abort_d_o",   l1_d_o,      8'h22);
    check_eq("abort_addr",  l1_mem_addr, 12'h020);
    check_eq("abort_re_ct", re_cnt - r0, 2);
    rd_n = 1'b1;
    repeat (2) tick();

    // early read, three-clock memory
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("l3_rst_err",  l3_err,  0);
    check_eq("l3_rst_d_oe", l3_d_oe, 0);
    mem_rdata = 8'hC3;
    ads_cycle(12'h030, 8'h10);
    rd_n = 1'b0;
    tick();
    check_eq("early_err",    l3_err,  1);
    check_eq("early_d_oe_1", l3_d_oe, 0);
    tick();
    check_eq("early_d_oe_2", l3_d_oe, 0);
    repeat (2) tick();
    check_eq("early_d_oe_4", l3_d_oe, 0);
    tick();
    check_eq("early_d_oe_5", l3_d_oe, 1);
    check_eq("early_d_o",    l3_d_o,  8'hC3);
    rd_n = 1'b1;
    repeat (2) tick();
    check_eq("early_d_oe_off", l3_d_oe, 0);

    // reset while waiting for a write
    w0 = we_cnt;
    ads_cycle(12'h040, 8'h00);
    rst_n = 1'b0;
    #2;
    check_eq("mrst_d_oe",   l1_d_oe,      0);
    check_eq("mrst_sel",    l1_sel,       0);
    check_eq("mrst_flags",  l1_flags,     0);
    check_eq("mrst_err",    l1_err,       0);
    check_eq("mrst_mem_we", l1_mem_we,    0);
    check_eq("mrst_mem_re", l1_mem_re,    0);
    check_eq("mrst_addr",   l1_mem_addr,  0);
    check_eq("mrst_wdata",  l1_mem_wdata, 0);
    check_eq("mrst_d_o",    l1_d_o,       0);
    wr_n = 1'b0;
    d_i  = 8'h55;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    wr_n = 1'b1;
    d_i  = 8'h00;
    tick();
    check_eq("mrst_no_we", we_cnt - w0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
